// File: rtl/bank_seq_ctrl.sv
// bank_seq_ctrl: multi-bank SRAM access sequencer.
// One access in flight at a time. The phases are WL -> (SENSE, reads only) -> RECOV,
// and the length of each phase is programmable. Every bank strobe is registered and
// decoded from the next state, so no input reaches a strobe combinationally.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is the registered IDLE decode ANDed with cs. The requester holds
// req_we/req_bank stable while req_valid is high. The sequencer latches them at accept.
module bank_seq_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int CNT_W     = 4,
  parameter int WL_CYC    = 2,
  parameter int SAE_CYC   = 1,
  parameter int PRE_CYC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BANK_W-1:0]    req_bank,
  output logic [NUM_BANKS-1:0] preb,
  output logic [NUM_BANKS-1:0] wl_en,
  output logic [NUM_BANKS-1:0] sae,
  output logic [NUM_BANKS-1:0] sampleb,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WL    = 2'd1,
    SENSE = 2'd2,
    RECOV = 2'd3
  } state_t;

  // A phase length of 0 is treated as 1. The counter is loaded with (length - 1).
  function automatic logic [CNT_W-1:0] len_m1(input int cyc);
    if (cyc <= 1) return '0;
    return CNT_W'(cyc - 1);
  endfunction

  localparam logic [CNT_W-1:0] WL_LD  = len_m1(WL_CYC);
  localparam logic [CNT_W-1:0] SAE_LD = len_m1(SAE_CYC);
  localparam logic [CNT_W-1:0] PRE_LD = len_m1(PRE_CYC);
  // One extra bit so that NUM_BANKS == 2**BANK_W still fits.
  localparam logic [BANK_W:0]  NB_LIM = (BANK_W+1)'(NUM_BANKS);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BANK_W-1:0]   bank_q, bank_n;
  logic                we_q, we_n;
  logic                idle_q;
  logic                accept;
  logic                hit;

  logic [NUM_BANKS-1:0] preb_n, wl_n, sae_n, sampleb_n, wr_n;
  logic                 rsp_n, err_n;

  assign req_ready = idle_q & cs;
  assign accept    = req_valid & req_ready;

  // Next-state, phase counter and request latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bank_n  = bank_q;
    we_n    = we_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = WL;
          cnt_n   = WL_LD;
          bank_n  = req_bank;
          we_n    = req_we;
        end
      end
      WL: begin
        if (cnt == '0) begin
          if (we_q) begin
            state_n = RECOV;
            cnt_n   = PRE_LD;
          end else begin
            state_n = SENSE;
            cnt_n   = SAE_LD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SENSE: begin
        if (cnt == '0) begin
          state_n = RECOV;
          cnt_n   = PRE_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RECOV: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Strobe decode from the next state. An out-of-range bank leaves every strobe idle.
  always_comb begin
    preb_n    = '0;
    wl_n      = '0;
    sae_n     = '0;
    sampleb_n = '1;
    wr_n      = '0;
    hit       = ({1'b0, bank_n} < NB_LIM);
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (hit && (bank_n == BANK_W'(i))) begin
        if (state_n == WL) begin
          preb_n[i] = 1'b1;
          wl_n[i]   = 1'b1;
          if (we_n) wr_n[i] = 1'b1;
          else      sampleb_n[i] = 1'b0;
        end else if (state_n == SENSE) begin
          preb_n[i] = 1'b1;
          sae_n[i]  = 1'b1;
        end
      end
    end
    rsp_n = (state_n == RECOV) && (state != RECOV);
    err_n = rsp_n && !hit;
  end

  // State, counter and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bank_q <= '0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bank_q <= bank_n;
      we_q   <= we_n;
    end
  end

  // Registered outputs. Reset forces all banks to precharge with the strobes released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preb      <= '0;
      wl_en     <= '0;
      sae       <= '0;
      sampleb   <= '1;
      wr_en     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      preb      <= preb_n;
      wl_en     <= wl_n;
      sae       <= sae_n;
      sampleb   <= sampleb_n;
      wr_en     <= wr_n;
      rsp_valid <= rsp_n;
      rsp_err   <= err_n;
      busy      <= (state_n != IDLE);
      idle_q    <= (state_n == IDLE);
    end
  end

  // Strobes are one-hot across banks, and no bank has its wordline and sense amp on together.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(wl_en) && $onehot0(sae) && $onehot0(wr_en) && ((wl_en & sae) == '0));

endmodule

// File: tb/tb_bank_seq_ctrl.sv
// tb_bank_seq_ctrl: directed vector table for the default configuration, plus
// hand-written sequences for reset abort, a longer write and an out-of-range bank.
module tb_bank_seq_ctrl;

  logic clk;
  logic rst_n;

  // Default instance (4 banks, WL_CYC=2, SAE_CYC=1, PRE_CYC=1)
  logic       cs, req_valid, req_we, req_ready;
  logic [1:0] req_bank;
  logic [3:0] preb, wl_en, sae, sampleb, wr_en;
  logic       rsp_valid, rsp_err, busy;

  // Alternate instance (3 banks, WL_CYC=3)
  logic       a_cs, a_valid, a_we, a_ready;
  logic [1:0] a_bank;
  logic [2:0] a_preb, a_wl, a_sae, a_sb, a_wr;
  logic       a_rsp, a_err, a_busy;

  int n_tests = 0;
  int n_fail  = 0;

  bank_seq_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .cs(cs), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bank(req_bank), .preb(preb), .wl_en(wl_en), .sae(sae),
    .sampleb(sampleb), .wr_en(wr_en), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy)
  );

  bank_seq_ctrl #(.NUM_BANKS(3), .BANK_W(2), .CNT_W(4), .WL_CYC(3), .SAE_CYC(1), .PRE_CYC(1)) u_alt (
    .clk(clk), .rst_n(rst_n), .cs(a_cs), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_bank(a_bank), .preb(a_preb), .wl_en(a_wl), .sae(a_sae),
    .sampleb(a_sb), .wr_en(a_wr), .rsp_valid(a_rsp), .rsp_err(a_err), .busy(a_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       cs, valid, we;
    logic [1:0] bank;
    logic       ready;
    logic [3:0] preb, wl, sae, sb, wr;
    logic       rsp, err, busy;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic c, v, w, input logic [1:0] b, input logic rdy,
                              input logic [3:0] p, wl, sa, sb, wr, input logic rs, er, bs);
    vec_t r;
    r.cs = c; r.valid = v; r.we = w; r.bank = b; r.ready = rdy;
    r.preb = p; r.wl = wl; r.sae = sa; r.sb = sb; r.wr = wr;
    r.rsp = rs; r.err = er; r.busy = bs;
    return r;
  endfunction

  function automatic logic [23:0] def_obs();
    return {req_ready, preb, wl_en, sae, sampleb, wr_en, rsp_valid, rsp_err, busy};
  endfunction

  function automatic logic [18:0] alt_obs();
    return {a_ready, a_preb, a_wl, a_sae, a_sb, a_wr, a_rsp, a_err, a_busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // Table: each entry is one cycle. Inputs are driven at the negedge and outputs
    // are compared 1 time unit later, so an entry with valid&ready is accepted at the next edge.
    //           cs v  we bank rdy preb     wl       sae      sampleb  wr       rsp err busy
    // read bank 2
    vt[0]  = mk(1, 1, 0, 2'd2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 2'd0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 0, 0, 1);
    vt[2]  = mk(1, 0, 0, 2'd0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 0, 0, 1);
    vt[3]  = mk(1, 0, 0, 2'd0, 0, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 4'b0000, 0, 0, 1);
    vt[4]  = mk(1, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 1);
    vt[5]  = mk(1, 0, 0, 2'd0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // back-to-back: read bank 0, then write bank 3 with valid held high
    vt[6]  = mk(1, 1, 0, 2'd0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    vt[7]  = mk(1, 1, 1, 2'd3, 0, 4'b0001, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0, 0, 1);
    vt[8]  = mk(1, 1, 1, 2'd3, 0, 4'b0001, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0, 0, 1);
    vt[9]  = mk(1, 1, 1, 2'd3, 0, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 0, 0, 1);
    vt[10] = mk(1, 1, 1, 2'd3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 1);
    vt[11] = mk(1, 1, 1, 2'd3, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    vt[12] = mk(1, 0, 0, 2'd0, 0, 4'b1000, 4'b1000, 4'b0000, 4'b1111, 4'b1000, 0, 0, 1);
    vt[13] = mk(1, 0, 0, 2'd0, 0, 4'b1000, 4'b1000, 4'b0000, 4'b1111, 4'b1000, 0, 0, 1);
    vt[14] = mk(1, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 1);
    vt[15] = mk(1, 0, 0, 2'd0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // cs low blocks accept; then cs drops mid-read of bank 1
    vt[16] = mk(0, 1, 0, 2'd1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    vt[17] = mk(0, 1, 0, 2'd1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    vt[18] = mk(1, 1, 0, 2'd1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    vt[19] = mk(0, 0, 0, 2'd0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0, 0, 1);
    vt[20] = mk(0, 0, 0, 2'd0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0, 0, 1);
    vt[21] = mk(0, 0, 0, 2'd0, 0, 4'b0010, 4'b0000, 4'b0010, 4'b1111, 4'b0000, 0, 0, 1);
    vt[22] = mk(0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 1);
    vt[23] = mk(0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    vt[24] = mk(1, 0, 0, 2'd0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);

    // Reset
    rst_n = 1'b0;
    cs = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_bank = '0;
    a_cs = 1'b1; a_valid = 1'b0; a_we = 1'b0; a_bank = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_def", 32'(def_obs()), 32'({1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 3'b000}));
    chk("reset_alt", 32'(alt_obs()), 32'({1'b1, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table on the default instance
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      cs = vt[i].cs; req_valid = vt[i].valid; req_we = vt[i].we; req_bank = vt[i].bank;
      #1;
      chk($sformatf("vec%0d", i), 32'(def_obs()),
          32'({vt[i].ready, vt[i].preb, vt[i].wl, vt[i].sae, vt[i].sb, vt[i].wr,
               vt[i].rsp, vt[i].err, vt[i].busy}));
    end

    // Reset mid-WL during a read to bank 1: outputs go idle at once, no response follows
    @(negedge clk);
    cs = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_bank = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rst_pre_wl", 32'(wl_en), 32'(4'b0010));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_abort", 32'(def_obs()), 32'({1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_quiet%0d", c), 32'({rsp_valid, busy, wl_en, sae}), 32'(0));
    end

    // Alternate instance: write to bank 0 with WL_CYC=3
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_bank = 2'd0;
    for (int c = 1; c <= 5; c++) begin
      logic [18:0] e;
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      if (c <= 3)      e = {1'b0, 3'b001, 3'b001, 3'b000, 3'b111, 3'b001, 3'b001};
      else if (c == 4) e = {1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b101};
      else             e = {1'b1, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000};
      chk($sformatf("alt_wr_c%0d", c), 32'(alt_obs()), 32'(e));
    end

    // Alternate instance: read of bank 3 with only 3 banks -> no strobes, rsp_err with rsp_valid
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b0; a_bank = 2'd3;
    for (int c = 1; c <= 6; c++) begin
      logic [18:0] e;
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      if (c <= 4)      e = {1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b001};
      else if (c == 5) e = {1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b111};
      else             e = {1'b1, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000};
      chk($sformatf("alt_oob_c%0d", c), 32'(alt_obs()), 32'(e));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
